// File: rtl/ats21_cmd_issuer_if.sv
// ats21_cmd_issuer_if: host-side command/response handshake of one ATS21 client.
interface ats21_cmd_issuer_if #(parameter int CTRL_WIDTH = 16);
    logic                    cmd_valid;
    logic [2*CTRL_WIDTH-1:0] cmd_data;
    logic                    cmd_ready;
    logic                    resp_valid;
    logic                    resp_ready;
    logic                    resp_ack;
    logic [2:0]              resp_opcode;
    modport master (
        output cmd_valid, cmd_data, resp_ready,
        input  cmd_ready, resp_valid, resp_ack, resp_opcode
    );
    modport slave (
        input  cmd_valid, cmd_data, resp_ready,
        output cmd_ready, resp_valid, resp_ack, resp_opcode
    );
endinterface

// File: rtl/ats21_cmd_issuer.sv
// ats21_cmd_issuer: serializes host instructions onto an ATS21 ctrl bus as two beats,
// returns the sampled Ack/Nack status and tracks alarm completion edges.
module ats21_cmd_issuer #(
    parameter int CTRL_WIDTH   = 16,
    parameter int NUM_ALARMS   = 24,
    parameter int STAT_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    ats21_cmd_issuer_if.slave     host,
    output logic                  req,
    output logic [CTRL_WIDTH-1:0] ctrl,
    input  logic                  stat_in,
    input  logic [NUM_ALARMS-1:0] alarm_data,
    input  logic [NUM_ALARMS-1:0] alarm_clear,
    output logic [NUM_ALARMS-1:0] alarm_pending,
    output logic                  alarm_irq
);
    typedef enum logic [2:0] {IDLE, HI, LO, WAIT, RESP} state_t;
    state_t                state;
    logic [CTRL_WIDTH-1:0] cmd_lo;
    logic [2:0]            cmd_op;
    logic [3:0]            cnt;
    logic [NUM_ALARMS-1:0] history;
    logic [NUM_ALARMS-1:0] pending_nxt;
    wire  [2:0]            in_op = host.cmd_data[2*CTRL_WIDTH-1 -: 3];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            cmd_lo           <= '0;
            cmd_op           <= '0;
            cnt              <= '0;
            req              <= 1'b0;
            ctrl             <= '0;
            host.cmd_ready   <= 1'b1;
            host.resp_valid  <= 1'b0;
            host.resp_ack    <= 1'b0;
            host.resp_opcode <= '0;
        end else begin
            case (state)
                IDLE: if (host.cmd_valid) begin
                    cmd_lo         <= host.cmd_data[CTRL_WIDTH-1:0];
                    cmd_op         <= in_op;
                    host.cmd_ready <= 1'b0;
                    if (in_op == 3'b000) begin
                        state            <= RESP;
                        host.resp_valid  <= 1'b1;
                        host.resp_ack    <= 1'b1;
                        host.resp_opcode <= in_op;
                    end else begin
                        state <= HI;
                        req   <= 1'b1;
                        ctrl  <= host.cmd_data[2*CTRL_WIDTH-1:CTRL_WIDTH];
                    end
                end
                HI: begin
                    state <= LO;
                    req   <= 1'b0;
                    ctrl  <= cmd_lo;
                end
                LO: begin
                    state <= WAIT;
                    ctrl  <= '0;
                    cnt   <= 4'(STAT_LATENCY);
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state            <= RESP;
                        host.resp_valid  <= 1'b1;
                        host.resp_ack    <= stat_in;
                        host.resp_opcode <= cmd_op;
                    end
                end
                RESP: if (host.resp_ready) begin
                    state           <= IDLE;
                    host.resp_valid <= 1'b0;
                    host.cmd_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // A fresh rising edge wins over a clear of the same bit
    always_comb pending_nxt = (alarm_pending & ~alarm_clear) | (alarm_data & ~history);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            history       <= '0;
            alarm_pending <= '0;
            alarm_irq     <= 1'b0;
        end else begin
            history       <= alarm_data;
            alarm_pending <= pending_nxt;
            alarm_irq     <= |pending_nxt;
        end
    end
endmodule

// File: tb/tb_ats21_cmd_issuer.sv
// tb_ats21_cmd_issuer: directed checks of the ATS21 command issuer.
module tb_ats21_cmd_issuer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req1, req3, irq1, irq3, stat_in;
    logic [15:0] ctrl1, ctrl3;
    logic [23:0] alarm_data, alarm_clear, pend1, pend3;
    int          assertions = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    ats21_cmd_issuer_if #(.CTRL_WIDTH(16)) h1 ();
    ats21_cmd_issuer_if #(.CTRL_WIDTH(16)) h3 ();

    ats21_cmd_issuer #(.STAT_LATENCY(1)) u1 (
        .clk(clk), .reset(reset), .host(h1.slave), .req(req1), .ctrl(ctrl1), .stat_in(stat_in),
        .alarm_data(alarm_data), .alarm_clear(alarm_clear), .alarm_pending(pend1), .alarm_irq(irq1)
    );
    ats21_cmd_issuer #(.STAT_LATENCY(3)) u3 (
        .clk(clk), .reset(reset), .host(h3.slave), .req(req3), .ctrl(ctrl3), .stat_in(stat_in),
        .alarm_data(alarm_data), .alarm_clear(alarm_clear), .alarm_pending(pend3), .alarm_irq(irq3)
    );

    task automatic issue(input logic [31:0] d);
        h1.cmd_data  = d;
        h1.cmd_valid = 1'b1;
        @(negedge clk);
        h1.cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        h1.cmd_valid = 0; h1.cmd_data = 0; h1.resp_ready = 0;
        h3.cmd_valid = 0; h3.cmd_data = 0; h3.resp_ready = 0;
        stat_in = 0; alarm_data = 0; alarm_clear = 0;
        repeat (2) @(negedge clk);
        assertions++; if (h1.cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_cmd_ready: got %b want 1", h1.cmd_ready); end
        assertions++; if ({h1.resp_valid, h1.resp_ack, h1.resp_opcode} !== 5'b0) begin failures++; $display("FAIL rst_resp: got %b want 00000", {h1.resp_valid, h1.resp_ack, h1.resp_opcode}); end
        assertions++; if ({req1, ctrl1} !== 17'h0) begin failures++; $display("FAIL rst_bus: got %h want 0", {req1, ctrl1}); end
        assertions++; if ({irq1, pend1} !== 25'h0) begin failures++; $display("FAIL rst_alarm: got %h want 0", {irq1, pend1}); end
        reset = 1'b1;
        @(negedge clk);
        assertions++; if (h1.cmd_ready !== 1'b1 || req1 !== 1'b0) begin failures++; $display("FAIL rst_release: got ready=%b req=%b want 1 0", h1.cmd_ready, req1); end
    endtask

    task automatic test_set_clock_ack;
        stat_in = 1'b1;
        issue(32'h2A40_0123);
        assertions++; if (req1 !== 1'b1 || ctrl1 !== 16'h2A40) begin failures++; $display("FAIL ack_hi_beat: got req=%b ctrl=%h want 1 2a40", req1, ctrl1); end
        assertions++; if (h1.cmd_ready !== 1'b0) begin failures++; $display("FAIL ack_ready_low: got %b want 0", h1.cmd_ready); end
        @(negedge clk);
        assertions++; if (req1 !== 1'b0 || ctrl1 !== 16'h0123) begin failures++; $display("FAIL ack_lo_beat: got req=%b ctrl=%h want 0 0123", req1, ctrl1); end
        @(negedge clk);
        assertions++; if (req1 !== 1'b0 || ctrl1 !== 16'h0 || h1.resp_valid !== 1'b0) begin failures++; $display("FAIL ack_wait: got req=%b ctrl=%h rv=%b want 0 0000 0", req1, ctrl1, h1.resp_valid); end
        @(negedge clk);
        assertions++; if ({h1.resp_valid, h1.resp_ack, h1.resp_opcode} !== 5'b11001) begin failures++; $display("FAIL ack_resp: got %b want 11001", {h1.resp_valid, h1.resp_ack, h1.resp_opcode}); end
        h1.resp_ready = 1'b1;
        @(negedge clk);
        h1.resp_ready = 1'b0;
        assertions++; if (h1.resp_valid !== 1'b0 || h1.cmd_ready !== 1'b1) begin failures++; $display("FAIL ack_done: got rv=%b ready=%b want 0 1", h1.resp_valid, h1.cmd_ready); end
    endtask

    task automatic test_resp_hold;
        stat_in = 1'b0;
        issue(32'h2A40_0123);
        @(negedge clk);
        h1.cmd_data = 32'hFFFF_FFFF;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            assertions++; if ({h1.resp_valid, h1.resp_ack, h1.resp_opcode, h1.cmd_ready} !== 6'b100010) begin failures++; $display("FAIL hold_resp_%0d: got %b want 100010", i, {h1.resp_valid, h1.resp_ack, h1.resp_opcode, h1.cmd_ready}); end
            if (i < 4) @(negedge clk);
        end
        h1.resp_ready = 1'b1;
        @(negedge clk);
        h1.resp_ready = 1'b0;
        h1.cmd_data = 32'h0;
        assertions++; if (h1.cmd_ready !== 1'b1 || h1.resp_valid !== 1'b0) begin failures++; $display("FAIL hold_release: got ready=%b rv=%b want 1 0", h1.cmd_ready, h1.resp_valid); end
    endtask

    task automatic test_nop;
        issue(32'h0000_0000);
        assertions++; if ({req1, h1.resp_valid, h1.resp_ack, h1.resp_opcode} !== 6'b011000) begin failures++; $display("FAIL nop_resp: got %b want 011000", {req1, h1.resp_valid, h1.resp_ack, h1.resp_opcode}); end
        h1.resp_ready = 1'b1;
        @(negedge clk);
        h1.resp_ready = 1'b0;
        assertions++; if (req1 !== 1'b0 || h1.resp_valid !== 1'b0 || h1.cmd_ready !== 1'b1) begin failures++; $display("FAIL nop_done: got req=%b rv=%b ready=%b want 0 0 1", req1, h1.resp_valid, h1.cmd_ready); end
    endtask

    task automatic test_alarm;
        alarm_data = 24'h000080;
        @(negedge clk);
        assertions++; if (pend1 !== 24'h000080 || irq1 !== 1'b1) begin failures++; $display("FAIL alarm_set7: got %h irq=%b want 000080 1", pend1, irq1); end
        @(negedge clk);
        assertions++; if (pend1 !== 24'h000080) begin failures++; $display("FAIL alarm_pulse_once: got %h want 000080", pend1); end
        alarm_data = 24'h000008; alarm_clear = 24'h000088;
        @(negedge clk);
        assertions++; if (pend1 !== 24'h000008 || irq1 !== 1'b1) begin failures++; $display("FAIL alarm_set_wins: got %h irq=%b want 000008 1", pend1, irq1); end
        assertions++; if (pend3 !== 24'h000008 || irq3 !== 1'b1) begin failures++; $display("FAIL alarm_set_wins_u3: got %h irq=%b want 000008 1", pend3, irq3); end
        alarm_clear = 24'h000008;
        @(negedge clk);
        alarm_clear = 24'h0;
        assertions++; if (pend1 !== 24'h0 || irq1 !== 1'b0) begin failures++; $display("FAIL alarm_clear: got %h irq=%b want 000000 0", pend1, irq1); end
        @(negedge clk);
        assertions++; if (pend1 !== 24'h0) begin failures++; $display("FAIL alarm_level_no_reset: got %h want 000000", pend1); end
        alarm_data = 24'h0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        stat_in = 1'b1;
        issue(32'h2A40_0123);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        assertions++; if ({req1, ctrl1, h1.resp_valid, h1.cmd_ready} !== 19'h1) begin failures++; $display("FAIL midrst_async: got %h want 00001", {req1, ctrl1, h1.resp_valid, h1.cmd_ready}); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            assertions++; if ({req1, ctrl1, h1.resp_valid} !== 18'h0) begin failures++; $display("FAIL midrst_held_%0d: got %h want 0", i, {req1, ctrl1, h1.resp_valid}); end
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            assertions++; if ({req1, h1.resp_valid, h1.cmd_ready} !== 3'b001) begin failures++; $display("FAIL midrst_after_%0d: got %b want 001", i, {req1, h1.resp_valid, h1.cmd_ready}); end
        end
    endtask

    task automatic test_back_to_back;
        int r0 = -1, r1 = -1, v0 = -1, consec = 0;
        logic prev = 1'b0;
        bit done = 1'b0;
        h3.cmd_data = 32'h2A40_0123;
        h3.resp_ready = 1'b1;
        h3.cmd_valid = 1'b1;
        for (int c = 0; c < 40 && r1 < 0; c++) begin
            @(negedge clk);
            if (req3 && prev) consec++;
            if (req3) begin
                if (r0 < 0) r0 = c;
                else r1 = c;
            end
            if (h3.resp_valid && v0 < 0) v0 = c;
            prev = req3;
        end
        h3.cmd_valid = 1'b0;
        assertions++; if (r1 < 0) begin failures++; $display("FAIL b2b_timeout: got %0d pulses want 2", (r0 < 0) ? 0 : 1); end
        assertions++; if (r1 - r0 !== 7) begin failures++; $display("FAIL b2b_spacing: got %0d want 7", r1 - r0); end
        assertions++; if (v0 - r0 !== 5) begin failures++; $display("FAIL b2b_resp_latency: got %0d want 5", v0 - r0); end
        assertions++; if (consec !== 0) begin failures++; $display("FAIL b2b_req_consec: got %0d want 0", consec); end
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            done = h3.cmd_ready;
        end
        assertions++; if (!done) begin failures++; $display("FAIL b2b_drain: got ready=%b want 1", h3.cmd_ready); end
        h3.resp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_set_clock_ack();
        test_resp_hold();
        test_nop();
        test_alarm();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule
